arc4_ctrl: RTL and testbench

Top-level sequencer for the ARC4 core. It accepts a start request and a key, then runs the three S-array stages in a fixed order: init (S[i]=i), then ksa, then prga. It owns the single port of the shared S memory and muxes it to whichever stage is active. It also supervises each stage with a watchdog timeout.

---
 rtl/arc4_ctrl_if.sv | 17 +
 rtl/arc4_ctrl.sv | 149 ++++++++++++++
 tb/tb_arc4_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_ctrl_if.sv
// Host-side handshake bundle for the ARC4 sequencer: start request, key,
// idle/done/error status and the active-stage code.
interface arc4_ctrl_if #(
    parameter int KEY_W = 24
) ();
    logic             en;
    logic             rdy;
    logic [KEY_W-1:0] key;
    logic             done;
    logic             err;
    logic [1:0]       stage;

    // The host drives the request and key and observes status.
    modport master (output en, output key, input rdy, input done, input err, input stage);
    // The controller observes the request and key and reports status.
    modport slave  (input en, input key, output rdy, output done, output err, output stage);
endinterface

// File: rtl/arc4_ctrl.sv
// ARC4 top-level sequencer. Runs init -> ksa -> prga on a start request,
// owns the single S-memory port and hands it to the active stage, and
// aborts any stage that stays busy longer than TIMEOUT cycles.
module arc4_ctrl #(
    parameter int KEY_W   = 24,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    arc4_ctrl_if.slave       host,
    output logic             init_en,
    input  logic             init_rdy,
    input  logic [7:0]       init_addr,
    input  logic [7:0]       init_wrdata,
    input  logic             init_wren,
    output logic             ksa_en,
    input  logic             ksa_rdy,
    output logic [KEY_W-1:0] ksa_key,
    input  logic [7:0]       ksa_addr,
    input  logic [7:0]       ksa_wrdata,
    input  logic             ksa_wren,
    output logic             prga_en,
    input  logic             prga_rdy,
    output logic [KEY_W-1:0] prga_key,
    input  logic [7:0]       prga_addr,
    input  logic [7:0]       prga_wrdata,
    input  logic             prga_wren,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN
    } state_t;

    state_t           r_state;
    logic             r_rdy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_stage;
    logic [KEY_W-1:0] r_key;
    logic [WD_W-1:0]  r_wdog;

    logic             w_sub_rdy;
    logic             w_expired;

    // Ready of whichever sub-block the current state is waiting on.
    always_comb begin
        w_sub_rdy = 1'b0;
        case (r_state)
            INIT_GO,  INIT_RUN: w_sub_rdy = init_rdy;
            KSA_GO,   KSA_RUN:  w_sub_rdy = ksa_rdy;
            PRGA_GO,  PRGA_RUN: w_sub_rdy = prga_rdy;
            default:            w_sub_rdy = 1'b0;
        endcase
    end

    // Watchdog saturates, so >= keeps the abort condition sticky past the limit.
    assign w_expired = (r_wdog >= WD_LAST);

    // Sequencer FSM with registered status outputs and the stage watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdy   <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_stage <= 2'd0;
            r_key   <= '0;
            r_wdog  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (host.en) begin
                        r_key   <= host.key;
                        r_err   <= 1'b0;
                        r_rdy   <= 1'b0;
                        r_stage <= 2'd1;
                        r_state <= INIT_GO;
                    end
                end
                INIT_GO: if (w_sub_rdy) begin r_state <= INIT_RUN; r_wdog <= '0; end
                KSA_GO:  if (w_sub_rdy) begin r_state <= KSA_RUN;  r_wdog <= '0; end
                PRGA_GO: if (w_sub_rdy) begin r_state <= PRGA_RUN; r_wdog <= '0; end
                INIT_RUN, KSA_RUN, PRGA_RUN: begin
                    // Completion is checked first so it wins over a same-cycle timeout.
                    if (w_sub_rdy) begin
                        case (r_state)
                            INIT_RUN: begin r_state <= KSA_GO;  r_stage <= 2'd2; end
                            KSA_RUN:  begin r_state <= PRGA_GO; r_stage <= 2'd3; end
                            default: begin
                                r_state <= IDLE;
                                r_stage <= 2'd0;
                                r_rdy   <= 1'b1;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end else if (w_expired) begin
                        r_state <= IDLE;
                        r_stage <= 2'd0;
                        r_rdy   <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Start pulses: only in the GO cycle where the sub-block reports idle.
    assign init_en = (r_state == INIT_GO) && init_rdy;
    assign ksa_en  = (r_state == KSA_GO)  && ksa_rdy;
    assign prga_en = (r_state == PRGA_GO) && prga_rdy;

    assign ksa_key  = r_key;
    assign prga_key = r_key;

    assign host.rdy   = r_rdy;
    assign host.done  = r_done;
    assign host.err   = r_err;
    assign host.stage = r_stage;

    // S-port mux: the owning stage gets the port, idle parks it at zero.
    always_comb begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
        case (r_state)
            INIT_GO, INIT_RUN: begin
                s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren;
            end
            KSA_GO, KSA_RUN: begin
                s_addr = ksa_addr;  s_wrdata = ksa_wrdata;  s_wren = ksa_wren;
            end
            PRGA_GO, PRGA_RUN: begin
                s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren;
            end
            default: begin
                s_addr = 8'h00; s_wrdata = 8'h00; s_wren = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_arc4_ctrl.sv
// Bench for arc4_ctrl: two instances (default watchdog and TIMEOUT=16)
// with behavioural init/ksa/prga busy models.
module tb_arc4_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arc4_ctrl_if #(.KEY_W(24)) host_a ();
    arc4_ctrl_if #(.KEY_W(24)) host_b ();

    logic [2:0]  en_a, en_b, rdy_a, rdy_b, hold_a, hold_b;
    logic [23:0] kk_a, kp_a, kk_b, kp_b;
    logic [7:0]  sa_a, sw_a, sa_b, sw_b;
    logic        swe_a, swe_b;
    logic [7:0]  in_addr [3];
    logic [7:0]  in_wd   [3];
    logic        in_wren [3];
    int          cnt_a [3], cnt_b [3], dur_a [3], dur_b [3];

    arc4_ctrl #(.KEY_W(24)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .host(host_a),
        .init_en(en_a[0]), .init_rdy(rdy_a[0]), .init_addr(in_addr[0]),
        .init_wrdata(in_wd[0]), .init_wren(in_wren[0]),
        .ksa_en(en_a[1]), .ksa_rdy(rdy_a[1]), .ksa_key(kk_a), .ksa_addr(in_addr[1]),
        .ksa_wrdata(in_wd[1]), .ksa_wren(in_wren[1]),
        .prga_en(en_a[2]), .prga_rdy(rdy_a[2]), .prga_key(kp_a), .prga_addr(in_addr[2]),
        .prga_wrdata(in_wd[2]), .prga_wren(in_wren[2]),
        .s_addr(sa_a), .s_wrdata(sw_a), .s_wren(swe_a)
    );

    arc4_ctrl #(.KEY_W(24), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .host(host_b),
        .init_en(en_b[0]), .init_rdy(rdy_b[0]), .init_addr(in_addr[0]),
        .init_wrdata(in_wd[0]), .init_wren(in_wren[0]),
        .ksa_en(en_b[1]), .ksa_rdy(rdy_b[1]), .ksa_key(kk_b), .ksa_addr(in_addr[1]),
        .ksa_wrdata(in_wd[1]), .ksa_wren(in_wren[1]),
        .prga_en(en_b[2]), .prga_rdy(rdy_b[2]), .prga_key(kp_b), .prga_addr(in_addr[2]),
        .prga_wrdata(in_wd[2]), .prga_wren(in_wren[2]),
        .s_addr(sa_b), .s_wrdata(sw_b), .s_wren(swe_b)
    );

    // Sub-block models: busy for dur cycles after sampling en, rdy drops next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 3; s++) begin cnt_a[s] <= 0; cnt_b[s] <= 0; end
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (en_a[s]) cnt_a[s] <= dur_a[s];
                else if (cnt_a[s] > 0) cnt_a[s] <= cnt_a[s] - 1;
                if (en_b[s]) cnt_b[s] <= dur_b[s];
                else if (cnt_b[s] > 0) cnt_b[s] <= cnt_b[s] - 1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            rdy_a[s] = (cnt_a[s] == 0) && !hold_a[s];
            rdy_b[s] = (cnt_b[s] == 0) && !hold_b[s];
        end
    end

    // Pulse monitors: per-stage start counts, start order and done counts.
    logic mon_clr;
    int   ien_a, ken_a, pen_a, ord_a, done_a, done_b;
    always @(posedge clk) begin
        if (mon_clr) begin
            ien_a <= 0; ken_a <= 0; pen_a <= 0; ord_a <= 0; done_a <= 0; done_b <= 0;
        end else begin
            if (en_a[0]) begin ien_a <= ien_a + 1; ord_a <= ord_a * 4 + 1; end
            if (en_a[1]) begin ken_a <= ken_a + 1; ord_a <= ord_a * 4 + 2; end
            if (en_a[2]) begin pen_a <= pen_a + 1; ord_a <= ord_a * 4 + 3; end
            if (host_a.done) done_a <= done_a + 1;
            if (host_b.done) done_b <= done_b + 1;
        end
    end

    // Status of whichever instance the current test targets.
    logic       sel;
    logic [1:0] cur_stage;
    logic       cur_done, cur_rdy, cur_err;
    always_comb begin
        cur_stage = sel ? host_b.stage : host_a.stage;
        cur_done  = sel ? host_b.done  : host_a.done;
        cur_rdy   = sel ? host_b.rdy   : host_a.rdy;
        cur_err   = sel ? host_b.err   : host_a.err;
    end

    typedef struct {
        logic [1:0] stg;
        logic [7:0] ia, iw; logic ie;
        logic [7:0] ka, kw; logic ke;
        logic [7:0] pa, pw; logic pe;
        logic [7:0] ea, ew; logic ee;
    } vec_t;
    vec_t vt [8];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply_vecs(input logic [1:0] stg);
        for (int i = 0; i < 8; i++) begin
            if (vt[i].stg == stg) begin
                in_addr[0] = vt[i].ia; in_wd[0] = vt[i].iw; in_wren[0] = vt[i].ie;
                in_addr[1] = vt[i].ka; in_wd[1] = vt[i].kw; in_wren[1] = vt[i].ke;
                in_addr[2] = vt[i].pa; in_wd[2] = vt[i].pw; in_wren[2] = vt[i].pe;
                #1;
                chk($sformatf("smux_vec%0d", i), {8'h0, sa_a, sw_a, 7'h0, swe_a},
                    {8'h0, vt[i].ea, vt[i].ew, 7'h0, vt[i].ee});
            end
        end
        for (int s = 0; s < 3; s++) begin in_addr[s] = 8'h0; in_wd[s] = 8'h0; in_wren[s] = 1'b0; end
    endtask

    task automatic wait_stage(input logic [1:0] s, input int budget, input string nm);
        int n = 0;
        while (cur_stage !== s && n < budget) begin @(negedge clk); n++; end
        nvec++;
        if (cur_stage !== s) begin
            nerr++;
            $display("FAIL %s: timed out with stage %0d, expected stage %0d", nm, cur_stage, s);
        end
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (cur_done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        nvec++;
        if (cur_done !== 1'b1) begin
            nerr++;
            $display("FAIL %s: no done within %0d cycles, got done=%0b expected 1", nm, budget, cur_done);
        end
    endtask

    task automatic start(input logic [23:0] k);
        if (sel) begin host_b.key = k; host_b.en = 1'b1; end
        else begin host_a.key = k; host_a.en = 1'b1; end
        @(negedge clk);
        host_a.en = 1'b0; host_b.en = 1'b0;
    endtask

    initial begin
        //                stg  ia     iw     ie    ka     kw     ke    pa     pw     pe    ea     ew     ee
        vt[0] = '{2'd0, 8'h55, 8'h11, 1'b1, 8'h66, 8'h22, 1'b1, 8'h77, 8'h33, 1'b1, 8'h00, 8'h00, 1'b0};
        vt[1] = '{2'd0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0};
        vt[2] = '{2'd1, 8'h10, 8'h20, 1'b1, 8'h30, 8'h40, 1'b1, 8'h50, 8'h60, 1'b1, 8'h10, 8'h20, 1'b1};
        vt[3] = '{2'd1, 8'h01, 8'h02, 1'b0, 8'h03, 8'h04, 1'b1, 8'h05, 8'h06, 1'b1, 8'h01, 8'h02, 1'b0};
        vt[4] = '{2'd2, 8'h55, 8'hAA, 1'b1, 8'h12, 8'h34, 1'b0, 8'h9A, 8'hBC, 1'b1, 8'h12, 8'h34, 1'b0};
        vt[5] = '{2'd2, 8'h55, 8'hAA, 1'b1, 8'h12, 8'h34, 1'b1, 8'h9A, 8'hBC, 1'b0, 8'h12, 8'h34, 1'b1};
        vt[6] = '{2'd3, 8'h55, 8'hAA, 1'b1, 8'h12, 8'h34, 1'b1, 8'hC3, 8'h3C, 1'b0, 8'hC3, 8'h3C, 1'b0};
        vt[7] = '{2'd3, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFE, 8'hEF, 1'b1, 8'hFE, 8'hEF, 1'b1};

        sel = 1'b0; mon_clr = 1'b1;
        hold_a = 3'b000; hold_b = 3'b000;
        dur_a[0] = 256; dur_a[1] = 768; dur_a[2] = 300;
        dur_b[0] = 3;   dur_b[1] = 3;   dur_b[2] = 1000;
        host_a.en = 1'b0; host_a.key = 24'h0; host_b.en = 1'b0; host_b.key = 24'h0;
        for (int s = 0; s < 3; s++) begin in_addr[s] = 8'h0; in_wd[s] = 8'h0; in_wren[s] = 1'b0; end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; mon_clr = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_rdy", 32'(host_a.rdy), 32'd1);
        chk("rst_done_err", {30'd0, host_a.done, host_a.err}, 32'd0);
        chk("rst_stage", 32'(host_a.stage), 32'd0);
        chk("rst_en", 32'(en_a), 32'd0);
        chk("rst_key", 32'(kk_a), 32'd0);
        chk("rst_sport", {8'h0, sa_a, sw_a, 7'h0, swe_a}, 32'd0);

        // Normal run on instance A, with ksa held busy in KSA_GO for 10 cycles.
        hold_a[1] = 1'b1;
        start(24'h00033C);
        chk("go_init_stage", 32'(host_a.stage), 32'd1);
        chk("go_init_rdy", 32'(host_a.rdy), 32'd0);
        chk("go_init_en", 32'(en_a), 32'b001);
        @(negedge clk);
        chk("init_run_en", 32'(en_a), 32'd0);
        apply_vecs(2'd1);
        wait_stage(2'd2, 400, "reach_ksa_go");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("ksa_stall%0d", i), {29'd0, en_a[1], host_a.stage}, {29'd0, 1'b0, 2'd2});
            @(negedge clk);
        end
        hold_a[1] = 1'b0;
        #1;
        chk("ksa_en_release", 32'(en_a), 32'b010);
        @(negedge clk);
        chk("ksa_run_state", {29'd0, en_a[1], host_a.stage}, {29'd0, 1'b0, 2'd2});
        repeat (5) @(negedge clk);
        apply_vecs(2'd2);

        // Key change plus start request during KSA_RUN must be ignored.
        start(24'hABCDEF);
        chk("ign_rdy", 32'(host_a.rdy), 32'd0);
        chk("ign_stage", 32'(host_a.stage), 32'd2);
        chk("ign_ksa_key", 32'(kk_a), 32'h00033C);
        chk("ign_prga_key", 32'(kp_a), 32'h00033C);

        wait_stage(2'd3, 900, "reach_prga");
        apply_vecs(2'd3);
        wait_done(400, "run_a_done");
        chk("done_rdy", 32'(host_a.rdy), 32'd1);
        chk("done_stage", 32'(host_a.stage), 32'd0);
        chk("done_err", 32'(host_a.err), 32'd0);
        @(negedge clk);
        chk("done_pulse_len", 32'(host_a.done), 32'd0);
        chk("start_counts", {8'd0, 8'(ien_a), 8'(ken_a), 8'(pen_a)}, 32'h00010101);
        chk("start_order", 32'(ord_a), 32'd27);
        chk("done_count_a", 32'(done_a), 32'd1);
        chk("key_after_run", 32'(kp_a), 32'h00033C);
        apply_vecs(2'd0);

        // Watchdog on instance B: prga never finishes.
        sel = 1'b1;
        start(24'h000001);
        wait_stage(2'd3, 100, "b_reach_prga");
        chk("b_prga_en", 32'(en_b), 32'b100);
        for (int i = 1; i <= 16; i++) @(negedge clk);
        chk("b_last_run_cycle", {30'd0, host_b.stage}, 32'd3);
        @(negedge clk);
        chk("b_to_stage", 32'(host_b.stage), 32'd0);
        chk("b_to_rdy_err", {30'd0, host_b.rdy, host_b.err}, 32'b11);
        chk("b_to_no_done", 32'(done_b), 32'd0);

        // Next run clears err; prga finishing on the last watchdog cycle completes.
        dur_b[2] = 15;
        start(24'h000002);
        chk("b_err_cleared", 32'(host_b.err), 32'd0);
        wait_done(1200, "b_boundary_done");
        chk("b_boundary_err", 32'(cur_err), 32'd0);
        @(negedge clk);
        chk("b_done_count", 32'(done_b), 32'd1);

        // Asynchronous reset in the middle of KSA on instance A.
        sel = 1'b0;
        start(24'h123456);
        wait_stage(2'd2, 400, "a2_reach_ksa");
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy", 32'(host_a.rdy), 32'd1);
        chk("arst_stage", 32'(host_a.stage), 32'd0);
        chk("arst_en", 32'(en_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start(24'h00033C);
        chk("arst_restart", {29'd0, en_a[0], host_a.stage}, {29'd0, 1'b1, 2'd1});
        chk("arst_cur_rdy", 32'(cur_rdy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
